// File: rtl/result_scanner.sv
// Result scanner: snapshots a ROWS x COLS result matrix on each rise of out_ready
// and lets the user step through it manually or with a timed auto-scroll.
module result_scanner #(
   parameter int DATA_WIDTH  = 16,
   parameter int ROWS        = 2,
   parameter int COLS        = 2,
   parameter int AUTO_PERIOD = 25000000,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            out_ready,
   input  logic [ROWS*COLS*DATA_WIDTH-1:0] matrix_in,
   input  logic                            next_pulse,
   input  logic                            prev_pulse,
   input  logic                            auto_en,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic [RW-1:0]                   row_idx,
   output logic [CW-1:0]                   col_idx,
   output logic                            data_valid,
   output logic                            last_item
);

   localparam int NUM = ROWS * COLS;
   localparam int TW  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   typedef enum logic [1:0] {IDLE, MANUAL, AUTO} state_t;

   state_t                state_q, state_d;
   logic                  readyDly_q;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [DATA_WIDTH-1:0] buf_q [NUM];

   logic captureRise;
   logic manualPulse;
   logic autoHit;
   logic stepFwd;
   logic stepBack;

   assign captureRise = out_ready && !readyDly_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         readyDly_q <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         timer_q    <= '0;
         for (int k = 0; k < NUM; k++) buf_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         readyDly_q <= out_ready;
         row_q      <= row_d;
         col_q      <= col_d;
         timer_q    <= timer_d;
         if (captureRise) begin
            for (int k = 0; k < NUM; k++) buf_q[k] <= matrix_in[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A capture overrides every step source; a manual pulse overrides a coincident auto step.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      timer_d     = timer_q;
      manualPulse = next_pulse || prev_pulse;
      autoHit     = (state_q == AUTO) && (timer_q == TW'(AUTO_PERIOD - 1));
      stepFwd     = 1'b0;
      stepBack    = 1'b0;
      if (captureRise) begin
         state_d = auto_en ? AUTO : MANUAL;
         row_d   = '0;
         col_d   = '0;
         timer_d = '0;
      end else if (state_q != IDLE) begin
         state_d  = auto_en ? AUTO : MANUAL;
         stepFwd  = (next_pulse && !prev_pulse) || (!manualPulse && autoHit);
         stepBack = prev_pulse && !next_pulse;
         if (state_q == AUTO && auto_en && !manualPulse && !autoHit) begin
            timer_d = timer_q + TW'(1);
         end else begin
            timer_d = '0;
         end
         if (stepFwd) begin
            if (col_q == CW'(COLS - 1)) begin
               col_d = '0;
               row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
         end else if (stepBack) begin
            if (col_q == '0) begin
               col_d = CW'(COLS - 1);
               row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
            end else begin
               col_d = col_q - CW'(1);
            end
         end
      end
   end

   always_comb begin
      data_out = '0;
      for (int k = 0; k < NUM; k++) begin
         if (k == int'(row_q) * COLS + int'(col_q)) data_out = buf_q[k];
      end
      row_idx    = row_q;
      col_idx    = col_q;
      data_valid = (state_q != IDLE);
      last_item  = data_valid && (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
   end

endmodule

// File: tb/tb_result_scanner.sv
// Directed bench for result_scanner with a 2x3 matrix and a 4-clock auto-scroll period.
module tb_result_scanner;

   localparam int DW   = 16;
   localparam int ROWS = 2;
   localparam int COLS = 3;
   localparam int AP   = 4;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic                   outReady;
   logic [ROWS*COLS*DW-1:0] matrixIn;
   logic                   nextPulse;
   logic                   prevPulse;
   logic                   autoEn;
   logic [DW-1:0]          dataOut;
   logic [0:0]             rowIdx;
   logic [1:0]             colIdx;
   logic                   dataValid;
   logic                   lastItem;

   int testsRun    = 0;
   int testsFailed = 0;

   result_scanner #(
      .DATA_WIDTH (DW),
      .ROWS       (ROWS),
      .COLS       (COLS),
      .AUTO_PERIOD(AP)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .out_ready (outReady),
      .matrix_in (matrixIn),
      .next_pulse(nextPulse),
      .prev_pulse(prevPulse),
      .auto_en   (autoEn),
      .data_out  (dataOut),
      .row_idx   (rowIdx),
      .col_idx   (colIdx),
      .data_valid(dataValid),
      .last_item (lastItem)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [15:0] d, input int r, input int c,
                           input logic v, input logic l);
      checkOutput({tag, ".data"}, 32'(dataOut), 32'(d));
      checkOutput({tag, ".row"}, 32'(rowIdx), 32'(r));
      checkOutput({tag, ".col"}, 32'(colIdx), 32'(c));
      checkOutput({tag, ".valid"}, 32'(dataValid), 32'(v));
      checkOutput({tag, ".last"}, 32'(lastItem), 32'(l));
   endtask

   task automatic loadMatrix(input logic [15:0] base);
      for (int k = 0; k < ROWS*COLS; k++) matrixIn[k*DW +: DW] = base + 16'(k);
   endtask

   task automatic applyStimulus(input logic nxt, input logic prv);
      nextPulse = nxt;
      prevPulse = prv;
      tick(1);
      nextPulse = 1'b0;
      prevPulse = 1'b0;
   endtask

   logic [15:0] fwdData [6];

   initial begin
      fwdData[0] = 16'h0012; fwdData[1] = 16'h0013; fwdData[2] = 16'h0014;
      fwdData[3] = 16'h0015; fwdData[4] = 16'h0016; fwdData[5] = 16'h0011;

      reset_n   = 1'b0;
      outReady  = 1'b0;
      matrixIn  = '0;
      nextPulse = 1'b0;
      prevPulse = 1'b0;
      autoEn    = 1'b0;
      tick(2);
      checkAll("reset", 16'h0, 0, 0, 1'b0, 1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0);
         tick(1);
      end
      checkAll("idle_pulses", 16'h0, 0, 0, 1'b0, 1'b0);

      loadMatrix(16'h0011);
      outReady = 1'b1;
      tick(1);
      checkAll("capture", 16'h0011, 0, 0, 1'b1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput($sformatf("fwd%0d.data", i), 32'(dataOut), 32'(fwdData[i]));
         checkOutput($sformatf("fwd%0d.last", i), 32'(lastItem), (i == 4) ? 32'd1 : 32'd0);
         if (i == 4) checkAll("fwd_end", 16'h0016, 1, 2, 1'b1, 1'b1);
      end
      checkAll("fwd_wrap", 16'h0011, 0, 0, 1'b1, 1'b0);

      applyStimulus(1'b0, 1'b1);
      checkAll("prev_wrap", 16'h0016, 1, 2, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      checkAll("both_pulses", 16'h0016, 1, 2, 1'b1, 1'b1);

      outReady = 1'b0;
      tick(1);
      checkAll("ready_fall", 16'h0016, 1, 2, 1'b1, 1'b1);

      autoEn = 1'b1;
      tick(4);
      checkAll("auto_wait", 16'h0016, 1, 2, 1'b1, 1'b1);
      tick(1);
      checkAll("auto_step1", 16'h0011, 0, 0, 1'b1, 1'b0);
      tick(2);
      applyStimulus(1'b1, 1'b0);
      checkAll("auto_manual", 16'h0012, 0, 1, 1'b1, 1'b0);
      tick(3);
      checkAll("auto_hold", 16'h0012, 0, 1, 1'b1, 1'b0);
      tick(1);
      checkAll("auto_step2", 16'h0013, 0, 2, 1'b1, 1'b0);

      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkAll("at_1_1", 16'h0015, 1, 1, 1'b1, 1'b0);

      loadMatrix(16'h0021);
      outReady = 1'b1;
      applyStimulus(1'b1, 1'b0);
      checkAll("recapture", 16'h0021, 0, 0, 1'b1, 1'b0);
      tick(1);
      checkAll("recapture_hold", 16'h0021, 0, 0, 1'b1, 1'b0);

      reset_n   = 1'b0;
      nextPulse = 1'b1;
      tick(1);
      nextPulse = 1'b0;
      checkAll("auto_reset", 16'h0, 0, 0, 1'b0, 1'b0);

      reset_n = 1'b1;
      tick(1);
      checkAll("release_rise", 16'h0021, 0, 0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
